// File: rtl/pwm_duty_sequencer_if.sv
// Command channel for the PWM duty sequencer: a valid/ready handshake
// carrying {generator, target duty, step per tick}.
interface pwm_duty_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_gen;
    logic [7:0] cmd_target;
    logic [3:0] cmd_step;

    modport master (
        output cmd_valid,
        output cmd_gen,
        output cmd_target,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_gen,
        input  cmd_target,
        input  cmd_step,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// PWM duty sequencer: a small command FIFO feeds four independent duty-cycle
// ramp generators. Each generator walks its duty toward a target by a fixed
// step on every PWM period tick, then pulses done for one cycle.
module pwm_duty_sequencer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_sequencer_if.slave  cmd,
    input  logic                 tick,
    input  logic                 hold,
    output logic [7:0]           duty_1,
    output logic [7:0]           duty_2,
    output logic [7:0]           duty_3,
    output logic [7:0]           duty_4,
    output logic [3:0]           busy,
    output logic [3:0]           done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } gen_state_t;

    // ------------------------------------------------------------------
    // Command FIFO. Entry layout: {gen[1:0], target[7:0], step[3:0]}.
    // The head is read combinationally so a command accepted on one edge
    // can be popped on the very next edge.
    // ------------------------------------------------------------------
    logic [13:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [13:0]   w_head;
    logic [1:0]    w_pop_gen;
    logic [7:0]    w_pop_target;
    logic [3:0]    w_pop_step;

    assign w_full        = (r_count == (AW+1)'(FIFO_DEPTH));
    // Ready is held low during reset so nothing is accepted into a FIFO
    // that is being cleared.
    assign cmd.cmd_ready = !w_full && !rst;
    assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
    assign w_pop         = (r_count != '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_pop_gen     = w_head[13:12];
    assign w_pop_target  = w_head[11:4];
    assign w_pop_step    = w_head[3:0];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.cmd_gen, cmd.cmd_target, cmd.cmd_step};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Four ramp generators.
    // ------------------------------------------------------------------
    logic [7:0] w_duty_all [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gen
            gen_state_t r_state;
            gen_state_t w_state_next;
            logic [7:0] r_duty;
            logic [7:0] w_duty_next;
            logic [7:0] r_target;
            logic [7:0] w_target_next;
            logic [3:0] r_step;
            logic [3:0] w_step_next;
            logic       r_done;
            logic       w_done_next;
            logic       w_pop_hit;
            logic [8:0] w_up_gap;
            logic [8:0] w_dn_gap;
            logic [7:0] w_ramp_duty;

            assign w_pop_hit = w_pop && (w_pop_gen == 2'(gi));
            assign w_up_gap  = {1'b0, r_target} - {1'b0, r_duty};
            assign w_dn_gap  = {1'b0, r_duty} - {1'b0, r_target};

            // One ramp step toward target, clamped so it never overshoots or wraps.
            always_comb begin
                w_ramp_duty = r_duty;
                if (r_step == 4'd0) begin
                    w_ramp_duty = r_target;
                end else if (r_duty < r_target) begin
                    if ({5'd0, r_step} >= w_up_gap) begin
                        w_ramp_duty = r_target;
                    end else begin
                        w_ramp_duty = r_duty + 8'(r_step);
                    end
                end else if (r_duty > r_target) begin
                    if ({5'd0, r_step} >= w_dn_gap) begin
                        w_ramp_duty = r_target;
                    end else begin
                        w_ramp_duty = r_duty - 8'(r_step);
                    end
                end
            end

            // Next-state logic: a pop to this generator wins over a tick and
            // leaves duty untouched; otherwise a qualifying tick advances the ramp.
            always_comb begin
                w_state_next  = r_state;
                w_duty_next   = r_duty;
                w_target_next = r_target;
                w_step_next   = r_step;
                w_done_next   = 1'b0;
                if (w_pop_hit) begin
                    w_target_next = w_pop_target;
                    w_step_next   = w_pop_step;
                    w_state_next  = S_RAMP;
                end else if ((r_state == S_RAMP) && tick && !hold) begin
                    w_duty_next = w_ramp_duty;
                    if (w_ramp_duty == r_target) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end

            // Generator state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state  <= S_IDLE;
                    r_duty   <= 8'd0;
                    r_target <= 8'd0;
                    r_step   <= 4'd0;
                    r_done   <= 1'b0;
                end else begin
                    r_state  <= w_state_next;
                    r_duty   <= w_duty_next;
                    r_target <= w_target_next;
                    r_step   <= w_step_next;
                    r_done   <= w_done_next;
                end
            end

            assign w_duty_all[gi] = r_duty;
            assign busy[gi]       = (r_state == S_RAMP);
            assign done[gi]       = r_done;
        end
    endgenerate

    assign duty_1 = w_duty_all[0];
    assign duty_2 = w_duty_all[1];
    assign duty_3 = w_duty_all[2];
    assign duty_4 = w_duty_all[3];

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed testbench for pwm_duty_sequencer with hand-computed expectations.
module tb_pwm_duty_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       hold;
    logic [7:0] duty_1;
    logic [7:0] duty_2;
    logic [7:0] duty_3;
    logic [7:0] duty_4;
    logic [3:0] busy;
    logic [3:0] done;

    int n_total;
    int n_bad;

    pwm_duty_sequencer_if cmd_if ();

    pwm_duty_sequencer #(.FIFO_DEPTH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cmd_if.slave),
        .tick   (tick),
        .hold   (hold),
        .duty_1 (duty_1),
        .duty_2 (duty_2),
        .duty_3 (duty_3),
        .duty_4 (duty_4),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for one edge (FIFO assumed ready).
    task automatic push(input logic [1:0] g, input logic [7:0] t, input logic [3:0] s);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_gen    = g;
        cmd_if.cmd_target = t;
        cmd_if.cmd_step   = s;
        cyc();
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        tick = 1'b0;
        hold = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_gen    = 2'd0;
        cmd_if.cmd_target = 8'd0;
        cmd_if.cmd_step   = 4'd0;

        // Reset state
        cyc();
        cyc();
        check_val("rst_ready", int'(cmd_if.cmd_ready), 0);
        check_val("rst_duty1", int'(duty_1), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        rst = 1'b0;
        #1;
        check_val("ready_after_rst", int'(cmd_if.cmd_ready), 1);

        // Ramp gen0 0 -> 100 by 10
        push(2'd0, 8'd100, 4'd10);
        check_val("g0_pre_pop_busy", int'(busy[0]), 0);
        cyc();
        check_val("g0_busy", int'(busy[0]), 1);
        check_val("g0_duty_at_pop", int'(duty_1), 0);
        for (int i = 0; i < 10; i++) begin
            pulse_tick();
            check_val($sformatf("g0_duty_t%0d", i + 1), int'(duty_1), 10 * (i + 1));
            check_val($sformatf("g0_done_t%0d", i + 1), int'(done[0]), (i == 9) ? 1 : 0);
        end
        check_val("g0_busy_end", int'(busy[0]), 0);
        cyc();
        check_val("g0_done_clear", int'(done[0]), 0);

        // gen1 jump to 50, then ramp down to 7 by 15
        push(2'd1, 8'd50, 4'd0);
        cyc();
        pulse_tick();
        check_val("g1_jump", int'(duty_2), 50);
        check_val("g1_jump_done", int'(done[1]), 1);
        push(2'd1, 8'd7, 4'd15);
        cyc();
        for (int i = 0; i < 4; i++) begin
            int exp_d [4] = '{35, 20, 7, 7};
            pulse_tick();
            check_val($sformatf("g1_duty_t%0d", i + 1), int'(duty_2), exp_d[i]);
            check_val($sformatf("g1_done_t%0d", i + 1), int'(done[1]), (i == 2) ? 1 : 0);
        end
        check_val("g1_busy_end", int'(busy[1]), 0);

        // gen2 jump to 200, then pop with target equal to current duty
        push(2'd2, 8'd200, 4'd0);
        cyc();
        pulse_tick();
        check_val("g2_jump", int'(duty_3), 200);
        check_val("g2_done", int'(done[2]), 1);
        cyc();
        check_val("g2_done_once", int'(done[2]), 0);
        push(2'd2, 8'd200, 4'd5);
        cyc();
        check_val("g2_eq_busy", int'(busy[2]), 1);
        pulse_tick();
        check_val("g2_eq_duty", int'(duty_3), 200);
        check_val("g2_eq_done", int'(done[2]), 1);
        check_val("g2_eq_idle", int'(busy[2]), 0);

        // Back-to-back pushes while popping each cycle
        begin
            logic [1:0] gens [4] = '{2'd0, 2'd1, 2'd0, 2'd3};
            logic [7:0] tgts [4] = '{8'd11, 8'd22, 8'd55, 8'd44};
            for (int k = 0; k < 4; k++) begin
                cmd_if.cmd_valid  = 1'b1;
                cmd_if.cmd_gen    = gens[k];
                cmd_if.cmd_target = tgts[k];
                cmd_if.cmd_step   = 4'd0;
                #1;
                check_val($sformatf("b2b_ready_%0d", k), int'(cmd_if.cmd_ready), 1);
                cyc();
            end
            cmd_if.cmd_valid = 1'b0;
        end
        cyc();
        pulse_tick();
        check_val("b2b_duty1_last", int'(duty_1), 55);
        check_val("b2b_duty2", int'(duty_2), 22);
        check_val("b2b_duty4", int'(duty_4), 44);
        check_val("b2b_done_all", int'(done), 4'b1011);

        // gen3: set to 30, ramp to 255 by 1, hold at 40
        push(2'd3, 8'd30, 4'd0);
        cyc();
        pulse_tick();
        check_val("g3_set30", int'(duty_4), 30);
        push(2'd3, 8'd255, 4'd1);
        cyc();
        for (int i = 0; i < 10; i++) pulse_tick();
        check_val("g3_at40", int'(duty_4), 40);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            check_val($sformatf("g3_hold_%0d", i), int'(duty_4), 40);
        end
        check_val("g3_hold_busy", int'(busy[3]), 1);
        hold = 1'b0;
        pulse_tick();
        check_val("g3_resume", int'(duty_4), 41);
        push(2'd3, 8'd255, 4'd2);
        pulse_tick();   // pop coincides with tick
        check_val("g3_pop_tick", int'(duty_4), 41);
        pulse_tick();
        check_val("g3_new_step", int'(duty_4), 43);

        // Reset mid-ramp with a command still queued
        push(2'd1, 8'd99, 4'd0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_ready", int'(cmd_if.cmd_ready), 0);
        cyc();
        check_val("mid_rst_duty1", int'(duty_1), 0);
        check_val("mid_rst_duty4", int'(duty_4), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_ready2", int'(cmd_if.cmd_ready), 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", int'(cmd_if.cmd_ready), 1);
        pulse_tick();
        check_val("post_rst_duty2", int'(duty_2), 0);
        check_val("post_rst_busy", int'(busy), 0);
        check_val("post_rst_done", int'(done), 0);
        pulse_tick();
        check_val("post_rst_done2", int'(done), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
